mem_write_buffer: RTL and testbench

MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

---
 rtl/cache_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 85 ++++++++
 rtl/mem_write_buffer.sv | 96 +++++++++
 tb/tb_mem_write_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM encoding and entry layout for the cache write path.
// Also holds the saturating increment used by the drain counter.
package cache_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int ADDR_WIDTH = 15;
    localparam int DRAIN_W    = 14;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_SIZE-1:0]  data;
    } wb_entry_t;

    function automatic logic [DRAIN_W-1:0] sat_inc(input logic [DRAIN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular entry store for the write buffer, with the snoop comparators and
// the coalesce comparators that decide between merging a write and appending it.
module wb_fifo
    import cache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  wb_entry_t             i_push_ent,
    input  logic                  i_pop,
    input  logic                  i_head_busy,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_match,
    output logic [WORD_SIZE-1:0]  o_rd_data,
    output wb_entry_t             o_head,
    output logic [3:0]            o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        r_ent [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [3:0]       r_count;

    logic             w_coal_hit;
    logic [PW-1:0]    w_coal_idx;
    logic [PW-1:0]    w_idx;
    logic             w_append;

    // Walk oldest to youngest so the last hit is the youngest. The head is
    // skipped for coalescing while it is being written to memory.
    always_comb begin
        w_coal_hit = 1'b0;
        w_coal_idx = r_tail;
        o_rd_match = 1'b0;
        o_rd_data  = '0;
        w_idx      = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (r_valid[w_idx] && r_ent[w_idx].addr == i_rd_addr) begin
                o_rd_match = 1'b1;
                o_rd_data  = r_ent[w_idx].data;
            end
            if (r_valid[w_idx] && r_ent[w_idx].addr == i_push_ent.addr &&
                !(i_head_busy && i == 0)) begin
                w_coal_hit = 1'b1;
                w_coal_idx = w_idx;
            end
        end
    end

    assign w_append = i_push && !w_coal_hit;
    assign o_head   = r_ent[r_head];
    assign o_count  = r_count;

    // Append and pop never hit the same slot: a full buffer refuses pushes
    // and an empty one is never in WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push && w_coal_hit) begin
                r_ent[w_coal_idx].data <= i_push_ent.data;
            end
            if (w_append) begin
                r_ent[r_tail]   <= i_push_ent;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            r_count <= r_count + 4'(w_append) - 4'(i_pop);
        end
    end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted write buffer between the cache and main memory: coalesces repeat
// addresses, answers line-fill snoops, and drains one entry at a time.
module mem_write_buffer
    import cache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [WORD_SIZE-1:0]  wr_data,
    output logic                  wr_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [WORD_SIZE-1:0]  mem_data,
    input  logic                  mem_ack,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic                  rd_match,
    output logic [WORD_SIZE-1:0]  rd_match_data,
    output logic                  empty,
    output logic [3:0]            count,
    output logic [DRAIN_W-1:0]    drain_count
);

    wb_state_t          r_state;
    logic               r_mem_write;
    logic [DRAIN_W-1:0] r_drain;

    wb_entry_t          w_head;
    wb_entry_t          w_push_ent;
    logic [3:0]         w_count;
    logic               w_accept;
    logic               w_pop;
    logic               w_head_busy;

    assign wr_ready    = (w_count < 4'(DEPTH));
    assign w_accept    = wr_req && wr_ready;
    assign w_head_busy = (r_state == WRITE);
    assign w_pop       = w_head_busy && mem_ack;
    assign w_push_ent  = '{addr: wr_address, data: wr_data};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_accept),
        .i_push_ent (w_push_ent),
        .i_pop      (w_pop),
        .i_head_busy(w_head_busy),
        .i_rd_addr  (rd_address),
        .o_rd_match (rd_match),
        .o_rd_data  (rd_match_data),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    // Returning to IDLE after every ack gives the one-cycle gap between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_write <= 1'b0;
            r_drain     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_count != 4'd0) begin
                        r_state     <= WRITE;
                        r_mem_write <= 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        r_state     <= IDLE;
                        r_mem_write <= 1'b0;
                        r_drain     <= sat_inc(r_drain);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    // The head cannot be coalesced into while in WRITE, so these stay stable.
    assign mem_write   = r_mem_write;
    assign mem_address = w_head_busy ? w_head.addr : '0;
    assign mem_data    = w_head_busy ? w_head.data : '0;
    assign empty       = (w_count == 4'd0) && (r_state == IDLE);
    assign count       = w_count;
    assign drain_count = r_drain;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: a hand-built vector table, directed corner
// sequences, and random traffic against a queue-based reference model.
module tb_mem_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, wr_req, mem_ack;
    logic [14:0] wr_address, rd_address;
    logic [31:0] wr_data;
    logic        wr_ready, mem_write, rd_match, empty;
    logic [14:0] mem_address;
    logic [31:0] mem_data, rd_match_data;
    logic [3:0]  count;
    logic [13:0] drain_count;

    always #5 clk = ~clk;

    mem_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_address(wr_address),
        .wr_data(wr_data), .wr_ready(wr_ready), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data(mem_data), .mem_ack(mem_ack),
        .rd_address(rd_address), .rd_match(rd_match), .rd_match_data(rd_match_data),
        .empty(empty), .count(count), .drain_count(drain_count)
    );

    int nvec = 0;
    int nbad = 0;

    // Reference model: queue of buffered writes, oldest first, plus a flag
    // saying whether the oldest is currently being written to memory.
    logic [14:0] qa[$];
    logic [31:0] qd[$];
    bit          m_busy;
    int          m_drain;

    task automatic model_edge(input logic r, input logic wq, input logic [14:0] wa,
                              input logic [31:0] wd, input logic ak);
        int n, j;
        bit pop, start;
        if (r) begin
            qa.delete(); qd.delete(); m_busy = 0; m_drain = 0;
            return;
        end
        n = qa.size();
        pop = m_busy && ak;
        start = !m_busy && n > 0;
        if (wq && n < DEPTH) begin
            j = -1;
            for (int k = n - 1; k >= 0 && j < 0; k--)
                if (qa[k] == wa && !(m_busy && k == 0)) j = k;
            if (j >= 0) qd[j] = wd;
            else begin qa.push_back(wa); qd.push_back(wd); end
        end
        if (pop) begin
            void'(qa.pop_front()); void'(qd.pop_front());
            m_busy = 0;
            if (m_drain < 16383) m_drain++;
        end else if (start) begin
            m_busy = 1;
        end
    endtask

    task automatic check_model();
        logic        e_mw, e_mt;
        logic [14:0] e_ma;
        logic [31:0] e_md, e_rd;
        int          n;
        n = qa.size();
        e_mw = m_busy; e_ma = '0; e_md = '0; e_mt = 1'b0; e_rd = '0;
        if (m_busy) begin e_ma = qa[0]; e_md = qd[0]; end
        for (int k = 0; k < n; k++)
            if (qa[k] == rd_address) begin e_mt = 1'b1; e_rd = qd[k]; end
        nvec++;
        if ({wr_ready, mem_write, mem_address, mem_data, rd_match, rd_match_data, empty, count, drain_count} !==
            {(n < DEPTH), e_mw, e_ma, e_md, e_mt, e_rd, (n == 0 && !m_busy), 4'(n), 14'(m_drain)}) begin
            nbad++;
            $display("FAIL model t=%0t got rdy=%b mw=%b ma=%h md=%h mt=%b rd=%h emp=%b cnt=%0d dr=%0d want rdy=%b mw=%b ma=%h md=%h mt=%b rd=%h emp=%b cnt=%0d dr=%0d",
                     $time, wr_ready, mem_write, mem_address, mem_data, rd_match, rd_match_data, empty, count, drain_count,
                     (n < DEPTH), e_mw, e_ma, e_md, e_mt, e_rd, (n == 0 && !m_busy), n, m_drain);
        end
    endtask

    // Drive one cycle of inputs, compare mid-cycle, advance the model over the edge.
    task automatic step(input logic r, input logic wq, input logic [14:0] wa,
                        input logic [31:0] wd, input logic ak, input logic [14:0] ra);
        rst = r; wr_req = wq; wr_address = wa; wr_data = wd; mem_ack = ak; rd_address = ra;
        #4;
        if (!r) check_model();
        model_edge(r, wq, wa, wd, ak);
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic wait_mw(input string nm);
        int w = 0;
        while (mem_write !== 1'b1 && w < 10) begin step(0, 0, 0, 0, 0, rd_address); w++; end
        chk(nm, mem_write, 1);
    endtask

    typedef struct {
        logic rst, wq; logic [14:0] wa; logic [31:0] wd; logic ak; logic [14:0] ra;
        logic rdy, mw; logic [14:0] ma; logic [31:0] md; logic mt; logic [31:0] rdat;
        logic emp; logic [3:0] cnt; logic [13:0] dr;
    } vec_t;

    function automatic vec_t mk(logic r, logic wq, logic [14:0] wa, logic [31:0] wd, logic ak,
                                logic rdy, logic mw, logic [14:0] ma, logic [31:0] md, logic mt,
                                logic [31:0] rdat, logic emp, logic [3:0] cnt, logic [13:0] dr);
        vec_t v;
        v.rst = r; v.wq = wq; v.wa = wa; v.wd = wd; v.ak = ak; v.ra = 15'h0010;
        v.rdy = rdy; v.mw = mw; v.ma = ma; v.md = md; v.mt = mt; v.rdat = rdat;
        v.emp = emp; v.cnt = cnt; v.dr = dr;
        return v;
    endfunction

    vec_t vt [10];

    initial begin
        rst = 1; wr_req = 0; wr_address = 0; wr_data = 0; mem_ack = 0; rd_address = 0;
        @(posedge clk); #1;

        // Single write 0x0010/DEADBEEF, ack two cycles after mem_write rises, then a stray ack.
        vt[0] = mk(1, 0, 0,       0,            0, 1, 0, 0,       0,            0, 0,            1, 0, 0);
        vt[1] = mk(0, 0, 0,       0,            0, 1, 0, 0,       0,            0, 0,            1, 0, 0);
        vt[2] = mk(0, 1, 15'h10,  32'hDEADBEEF, 0, 1, 0, 0,       0,            0, 0,            1, 0, 0);
        vt[3] = mk(0, 0, 0,       0,            0, 1, 0, 0,       0,            1, 32'hDEADBEEF, 0, 1, 0);
        vt[4] = mk(0, 0, 0,       0,            0, 1, 1, 15'h10,  32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 1, 0);
        vt[5] = mk(0, 0, 0,       0,            0, 1, 1, 15'h10,  32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 1, 0);
        vt[6] = mk(0, 0, 0,       0,            1, 1, 1, 15'h10,  32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 1, 0);
        vt[7] = mk(0, 0, 0,       0,            0, 1, 0, 0,       0,            0, 0,            1, 0, 1);
        vt[8] = mk(0, 0, 0,       0,            1, 1, 0, 0,       0,            0, 0,            1, 0, 1);
        vt[9] = mk(0, 0, 0,       0,            0, 1, 0, 0,       0,            0, 0,            1, 0, 1);

        for (int i = 0; i < 10; i++) begin
            rst = vt[i].rst; wr_req = vt[i].wq; wr_address = vt[i].wa; wr_data = vt[i].wd;
            mem_ack = vt[i].ak; rd_address = vt[i].ra;
            #4;
            if (!vt[i].rst) begin
                nvec++;
                if ({wr_ready, mem_write, mem_address, mem_data, rd_match, rd_match_data, empty, count, drain_count} !==
                    {vt[i].rdy, vt[i].mw, vt[i].ma, vt[i].md, vt[i].mt, vt[i].rdat, vt[i].emp, vt[i].cnt, vt[i].dr}) begin
                    nbad++;
                    $display("FAIL vec%0d got rdy=%b mw=%b ma=%h md=%h mt=%b rd=%h emp=%b cnt=%0d dr=%0d want rdy=%b mw=%b ma=%h md=%h mt=%b rd=%h emp=%b cnt=%0d dr=%0d",
                             i, wr_ready, mem_write, mem_address, mem_data, rd_match, rd_match_data, empty, count, drain_count,
                             vt[i].rdy, vt[i].mw, vt[i].ma, vt[i].md, vt[i].mt, vt[i].rdat, vt[i].emp, vt[i].cnt, vt[i].dr);
                end
            end
            model_edge(vt[i].rst, vt[i].wq, vt[i].wa, vt[i].wd, vt[i].ak);
            @(posedge clk); #1;
        end

        // Fill with no acks: four accepted, fifth dropped.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 15'(16'h0100 + i), 32'h5000 + i, 0, 15'h0104);
            if (i == 3) chk("ready_after_4th", wr_ready, 0);
        end
        chk("full_count", count, 4);
        chk("full_ready", wr_ready, 0);
        chk("fifth_dropped", rd_match, 0);

        // Coalesce behind an in-flight head.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 15'h0020, 32'h11111111, 0, 0);
        wait_mw("coal_first_write");
        step(0, 1, 15'h0030, 32'h22222222, 0, 0);
        step(0, 1, 15'h0030, 32'h33333333, 0, 0);
        chk("coal_count", count, 2);
        step(0, 0, 0, 0, 1, 0);
        chk("coal_gap", mem_write, 0);
        wait_mw("coal_second_write");
        chk("coal_addr", mem_address, 32'h0030);
        chk("coal_data", mem_data, 32'h33333333);

        // Head in flight matches, so a second entry is appended; snoop sees the younger one.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 15'h0040, 32'hA, 0, 0);
        wait_mw("snoop_write");
        step(0, 1, 15'h0040, 32'hB, 0, 15'h0040);
        chk("snoop_count", count, 2);
        chk("snoop_match", rd_match, 1);
        chk("snoop_data", rd_match_data, 32'hB);

        // Reset mid-WRITE, then an orphan ack.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 15'h0050, 32'h1, 0, 0);
        step(0, 1, 15'h0051, 32'h2, 0, 0);
        step(0, 1, 15'h0052, 32'h3, 0, 0);
        wait_mw("rst_pre_write");
        chk("rst_pre_count", count, 3);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("rst_mw", mem_write, 0);
        chk("rst_count", count, 0);
        chk("rst_drain", drain_count, 0);
        chk("rst_empty", empty, 1);

        // Random traffic over a small address set to exercise coalescing and snoops.
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 99) == 0, ($urandom % 10) < 6, 15'($urandom_range(0, 5)),
                 $urandom, ($urandom % 10) < 4, 15'($urandom_range(0, 6)));

        // Drain counter saturation under continuous traffic.
        step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 40000 && m_drain < 16383; c++)
            step(0, 1, 15'(c % 3), 32'(c), 1, 0);
        for (int c = 0; c < 6; c++)
            step(0, 1, 15'(c % 3), 32'(c), 1, 0);
        chk("drain_saturated", drain_count, 16383);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
